// File: rtl/tube_arbiter.sv
// -----------------------------------------------------------------------------
// tube_arbiter
//
// Shares the seven-segment tube display device between two bus masters
// (port 0: CPU bridge, port 1: debug/switch overlay). Each port issues
// single-word read/write transactions with a req/ack handshake; the arbiter
// serializes them onto the device's single we/addr/din/dout port using
// round-robin fairness plus an optional bounded lock, so a master can update
// the low word (addr 6) and high nibble (addr 7) back to back.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_pN_req                  transaction request (held until ack)
//   i_pN_we                   1 = write, 0 = read
//   i_pN_addr [2:0]           device word address (6 and 7 legal)
//   i_pN_din  [31:0]          write data
//   i_pN_lock                 keep ownership for the next transaction
//   o_pN_ack                  one-cycle completion pulse
//   o_pN_err                  one-cycle illegal-address pulse (with ack)
//   o_pN_rdata [31:0]         registered read data
//   o_dev_we, o_dev_addr, o_dev_din, i_dev_dout   device port
//
// State | meaning
//   IDLE | waiting for a request; picks a winner and latches its command
//   XFER | command on the device port; read data captured at cycle end
//   ACK  | ack/err pulse to the winner; fairness and lock bookkeeping
// -----------------------------------------------------------------------------
module tube_arbiter #(
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_p0_req,
    input  logic        i_p1_req,
    input  logic        i_p0_we,
    input  logic        i_p1_we,
    input  logic [2:0]  i_p0_addr,
    input  logic [2:0]  i_p1_addr,
    input  logic [31:0] i_p0_din,
    input  logic [31:0] i_p1_din,
    input  logic        i_p0_lock,
    input  logic        i_p1_lock,
    output logic        o_p0_ack,
    output logic        o_p1_ack,
    output logic        o_p0_err,
    output logic        o_p1_err,
    output logic [31:0] o_p0_rdata,
    output logic [31:0] o_p1_rdata,
    output logic        o_dev_we,
    output logic [2:0]  o_dev_addr,
    output logic [31:0] o_dev_din,
    input  logic [31:0] i_dev_dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_LIM = 4'(LOCK_MAX);

    state_t      r_state;
    logic        r_win;
    logic        r_we;
    logic [2:0]  r_addr;
    logic [31:0] r_din;
    logic        r_last;
    logic        r_lock_vld;
    logic        r_lock_own;
    logic [3:0]  r_lock_cnt;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;

    state_t      w_state_nxt;
    logic        w_win_nxt;
    logic        w_load;
    logic        w_lock_vld_nxt;
    logic        w_lock_own_nxt;
    logic [3:0]  w_lock_cnt_nxt;
    logic [1:0]  w_req;
    logic [1:0]  w_lock_in;
    logic        w_own_req;
    logic        w_legal;
    logic        w_sel_we;
    logic [2:0]  w_sel_addr;
    logic [31:0] w_sel_din;
    logic [31:0] w_rd_val;

    assign w_req     = {i_p1_req, i_p0_req};
    assign w_lock_in = {i_p1_lock, i_p0_lock};
    assign w_own_req = w_req[r_lock_own];
    assign w_legal   = (r_addr == 3'b110) || (r_addr == 3'b111);

    assign w_sel_we   = w_win_nxt ? i_p1_we   : i_p0_we;
    assign w_sel_addr = w_win_nxt ? i_p1_addr : i_p0_addr;
    assign w_sel_din  = w_win_nxt ? i_p1_din  : i_p0_din;

    // Illegal reads return zero rather than whatever the device drives.
    assign w_rd_val = w_legal ? i_dev_dout : 32'd0;

    always_comb begin
        w_state_nxt    = r_state;
        w_win_nxt      = r_win;
        w_load         = 1'b0;
        w_lock_vld_nxt = r_lock_vld;
        w_lock_own_nxt = r_lock_own;
        w_lock_cnt_nxt = r_lock_cnt;
        case (r_state)
            S_IDLE: begin
                // Owner stopped requesting: the lock is released.
                if (r_lock_vld && !w_own_req) begin
                    w_lock_vld_nxt = 1'b0;
                    w_lock_cnt_nxt = 4'd0;
                end
                if (w_req != 2'b00) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_XFER;
                    if (r_lock_vld && w_own_req && (r_lock_cnt < LOCK_LIM)) begin
                        w_win_nxt = r_lock_own;
                    end else if (r_lock_vld && w_own_req) begin
                        // Lock exhausted: yield once if the other port waits,
                        // otherwise serve the owner and restart the count.
                        w_lock_vld_nxt = 1'b0;
                        if (w_req[~r_lock_own]) begin
                            w_win_nxt      = ~r_lock_own;
                            w_lock_cnt_nxt = 4'd0;
                        end else begin
                            w_win_nxt      = r_lock_own;
                            w_lock_cnt_nxt = 4'd1;
                        end
                    end else if (w_req == 2'b11) begin
                        w_win_nxt = ~r_last;
                    end else begin
                        w_win_nxt = w_req[1];
                    end
                end
            end
            S_XFER: begin
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
                if (w_lock_in[r_win]) begin
                    w_lock_vld_nxt = 1'b1;
                    w_lock_own_nxt = r_win;
                    if (r_lock_vld && (r_lock_own == r_win)) begin
                        w_lock_cnt_nxt = r_lock_cnt + 4'd1;
                    end else begin
                        w_lock_cnt_nxt = 4'd1;
                    end
                end else begin
                    w_lock_vld_nxt = 1'b0;
                    w_lock_cnt_nxt = 4'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_win      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 3'd0;
            r_din      <= 32'd0;
            r_last     <= 1'b1;
            r_lock_vld <= 1'b0;
            r_lock_own <= 1'b0;
            r_lock_cnt <= 4'd0;
            r_rdata0   <= 32'd0;
            r_rdata1   <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_win      <= w_win_nxt;
            r_lock_vld <= w_lock_vld_nxt;
            r_lock_own <= w_lock_own_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            if (w_load) begin
                r_we   <= w_sel_we;
                r_addr <= w_sel_addr;
                r_din  <= w_sel_din;
            end
            if ((r_state == S_XFER) && !r_we) begin
                if (r_win) begin
                    r_rdata1 <= w_rd_val;
                end else begin
                    r_rdata0 <= w_rd_val;
                end
            end
            if (r_state == S_ACK) begin
                r_last <= r_win;
            end
        end
    end

    // Decoded straight from state so an async reset drops them immediately.
    assign o_dev_we   = (r_state == S_XFER) && r_we && w_legal;
    assign o_dev_addr = r_addr;
    assign o_dev_din  = r_din;
    assign o_p0_ack   = (r_state == S_ACK) && !r_win;
    assign o_p1_ack   = (r_state == S_ACK) && r_win;
    assign o_p0_err   = o_p0_ack && !w_legal;
    assign o_p1_err   = o_p1_ack && !w_legal;
    assign o_p0_rdata = r_rdata0;
    assign o_p1_rdata = r_rdata1;

endmodule

// File: tb/tb_tube_arbiter.sv
module tb_tube_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p1_req = 1'b0;
    logic        p0_we = 1'b0, p1_we = 1'b0;
    logic [2:0]  p0_addr = 3'd0, p1_addr = 3'd0;
    logic [31:0] p0_din = 32'd0, p1_din = 32'd0;
    logic        p0_lock = 1'b0, p1_lock = 1'b0;
    logic        p0_ack, p1_ack, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        dev_we;
    logic [2:0]  dev_addr;
    logic [31:0] dev_din;
    logic [31:0] dev_dout;

    always #5 clk = ~clk;

    tube_arbiter #(.LOCK_MAX(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_p0_req(p0_req), .i_p1_req(p1_req),
        .i_p0_we(p0_we), .i_p1_we(p1_we),
        .i_p0_addr(p0_addr), .i_p1_addr(p1_addr),
        .i_p0_din(p0_din), .i_p1_din(p1_din),
        .i_p0_lock(p0_lock), .i_p1_lock(p1_lock),
        .o_p0_ack(p0_ack), .o_p1_ack(p1_ack),
        .o_p0_err(p0_err), .o_p1_err(p1_err),
        .o_p0_rdata(p0_rdata), .o_p1_rdata(p1_rdata),
        .o_dev_we(dev_we), .o_dev_addr(dev_addr), .o_dev_din(dev_din),
        .i_dev_dout(dev_dout)
    );

    // Device model: low word at 6, high nibble at 7, garbage elsewhere.
    logic [31:0] dev_lo = 32'd0;
    logic [3:0]  dev_hi = 4'd0;
    always_comb begin
        case (dev_addr)
            3'd6:    dev_dout = dev_lo;
            3'd7:    dev_dout = {28'd0, dev_hi};
            default: dev_dout = 32'hDEADBEEF;
        endcase
    end
    always @(posedge clk) begin
        if (dev_we) begin
            if (dev_addr == 3'd6) dev_lo <= dev_din;
            else if (dev_addr == 3'd7) dev_hi <= dev_din[3:0];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected acks.
    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_we = 1'b0;

    task automatic push(input int p, input logic e, input logic [31:0] rd);
        exp_t x;
        x.port = p; x.err = e; x.rdata = rd;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (dev_we) chk("dev_we_single_cycle", 32'(prev_we), 32'd0);
            chk("err_only_with_ack", 32'((p0_err & ~p0_ack) | (p1_err & ~p1_ack)), 32'd0);
            if (p0_ack || p1_ack) begin
                chk("ack_onehot", 32'(p0_ack & p1_ack), 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_ack observed p0=%0b p1=%0b expected none", p0_ack, p1_ack);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_port", p1_ack ? 32'd1 : 32'd0, 32'(mon_e.port));
                    chk("ack_err", 32'(p1_ack ? p1_err : p0_err), 32'(mon_e.err));
                    chk("ack_rdata", p1_ack ? p1_rdata : p0_rdata, mon_e.rdata);
                end
            end
            prev_we = dev_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    // Bench-side shadow of device contents and expected per-port rdata.
    logic [31:0] m_lo = 32'd0;
    logic [3:0]  m_hi = 4'd0;
    logic [31:0] exp_rd [2] = '{32'd0, 32'd0};

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ack(output int p, output int at);
        bit got = 0;
        p = -1; at = -1;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (p0_ack || p1_ack) begin
                got = 1;
                p = p1_ack ? 1 : 0;
                at = cyc;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL ack_timeout observed no ack expected ack within 30 cycles");
        end
    endtask

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [2:0] a, input logic [31:0] d, input logic lk);
        if (p == 0) begin
            p0_req = req; p0_we = we; p0_addr = a; p0_din = d; p0_lock = lk;
        end else begin
            p1_req = req; p1_we = we; p1_addr = a; p1_din = d; p1_lock = lk;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_port(0, 0, 0, 3'd0, 32'd0, 0);
        set_port(1, 0, 0, 3'd0, 32'd0, 0);
        tick(); tick();
        rst_n = 1'b1;
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        tick();
    endtask

    // Single transaction from one port with latency and device-port checks.
    task automatic xact(input int p, input logic we, input logic [2:0] a, input logic [31:0] d);
        logic legal;
        int   c0, pa, at;
        legal = (a == 3'd6) || (a == 3'd7);
        if (!we) exp_rd[p] = !legal ? 32'd0 : (a == 3'd6) ? m_lo : {28'd0, m_hi};
        push(p, !legal, exp_rd[p]);
        set_port(p, 1, we, a, d, 0);
        c0 = cyc;
        tick();
        chk("xfer_dev_we", 32'(dev_we), 32'(we && legal));
        chk("xfer_dev_addr", 32'(dev_addr), 32'(a));
        if (we) chk("xfer_dev_din", dev_din, d);
        wait_ack(pa, at);
        chk("xact_port", 32'(pa), 32'(p));
        chk("xact_latency", 32'(at - c0), 32'd2);
        set_port(p, 0, we, a, d, 0);
        if (we && a == 3'd6) m_lo = d;
        if (we && a == 3'd7) m_hi = d[3:0];
        tick();
    endtask

    int pa, at, prev_at;
    int order [6];

    initial begin
        // Reset state
        tick();
        chk("rst_outputs", {25'd0, p0_ack, p1_ack, p0_err, p1_err, dev_we, dev_addr != 3'd0, dev_din != 32'd0},
            32'd0);
        chk("rst_rdata0", p0_rdata, 32'd0);
        chk("rst_rdata1", p1_rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single write with explicit per-cycle timing
        push(0, 1'b0, exp_rd[0]);
        set_port(0, 1, 1, 3'd6, 32'h12345678, 0);
        tick();
        chk("w1_dev_we", 32'(dev_we), 32'd1);
        chk("w1_dev_addr", 32'(dev_addr), 32'd6);
        chk("w1_dev_din", dev_din, 32'h12345678);
        chk("w1_no_ack_in_xfer", 32'(p0_ack | p1_ack), 32'd0);
        tick();
        chk("w1_dev_we_off", 32'(dev_we), 32'd0);
        chk("w1_p0_ack", 32'(p0_ack), 32'd1);
        chk("w1_p1_ack", 32'(p1_ack), 32'd0);
        set_port(0, 0, 1, 3'd6, 32'h12345678, 0);
        m_lo = 32'h12345678;
        tick();
        chk("w1_device_lo", dev_lo, 32'h12345678);
        tick();

        // Read path on port 1, with data held afterwards
        xact(0, 1, 3'd7, 32'h0000000A);
        xact(1, 0, 3'd7, 32'd0);
        xact(0, 1, 3'd7, 32'h00000005);
        chk("rd_hold_p1", p1_rdata, 32'h0000000A);
        xact(1, 0, 3'd6, 32'd0);

        // Tie and fairness right after reset
        do_reset();
        set_port(0, 1, 1, 3'd6, 32'h11110000, 0);
        set_port(1, 1, 0, 3'd6, 32'd0, 0);
        push(0, 0, exp_rd[0]);
        push(1, 0, 32'h11110000);
        push(0, 0, exp_rd[0]);
        push(1, 0, 32'h11110000);
        exp_rd[1] = 32'h11110000;
        m_lo = 32'h11110000;
        prev_at = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(pa, at);
            chk("tie_order", 32'(pa), 32'(i % 2));
            if (i > 0) chk("tie_spacing", 32'(at - prev_at), 32'd3);
            prev_at = at;
        end
        set_port(0, 0, 1, 3'd6, 32'h11110000, 0);
        set_port(1, 0, 0, 3'd6, 32'd0, 0);
        tick();

        // Lock bound: p1 locks, p0 joins after p1's first grant
        set_port(1, 1, 0, 3'd7, 32'd0, 1);
        push(1, 0, {28'd0, m_hi});
        exp_rd[1] = {28'd0, m_hi};
        wait_ack(pa, at);
        chk("lock_first", 32'(pa), 32'd1);
        set_port(0, 1, 1, 3'd6, 32'h22220000, 0);
        order = '{1, 1, 1, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            if (order[i] == 1) push(1, 0, exp_rd[1]);
            else push(0, 0, exp_rd[0]);
        end
        prev_at = at;
        for (int i = 0; i < 5; i++) begin
            wait_ack(pa, at);
            chk("lock_order", 32'(pa), 32'(order[i]));
            chk("lock_spacing", 32'(at - prev_at), 32'd3);
            prev_at = at;
            if (i == 3) set_port(0, 0, 1, 3'd6, 32'h22220000, 0);
        end
        set_port(1, 0, 0, 3'd7, 32'd0, 0);
        m_lo = 32'h22220000;
        tick();

        // Illegal addresses
        xact(0, 1, 3'd3, 32'hFFFFFFFF);
        xact(0, 0, 3'd6, 32'd0);
        chk("legal_read_p0", p0_rdata, 32'h22220000);
        xact(0, 0, 3'd0, 32'd0);
        xact(1, 0, 3'd5, 32'd0);
        chk("illegal_no_write", dev_lo, 32'h22220000);

        // Reset abort during XFER
        set_port(0, 1, 1, 3'd6, 32'hCAFEF00D, 0);
        tick();
        chk("abort_we_in_xfer", 32'(dev_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_we_drop", 32'(dev_we), 32'd0);
        chk("abort_acks_drop", 32'({p0_ack, p1_ack}), 32'd0);
        set_port(0, 0, 1, 3'd6, 32'hCAFEF00D, 0);
        tick(); tick();
        rst_n = 1'b1;
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        tick(); tick(); tick();
        chk("abort_no_write", dev_lo, 32'h22220000);
        set_port(0, 1, 0, 3'd6, 32'd0, 0);
        set_port(1, 1, 1, 3'd7, 32'h00000003, 0);
        push(0, 0, m_lo);
        push(1, 0, 32'd0);
        wait_ack(pa, at);
        chk("abort_tie_p0", 32'(pa), 32'd0);
        set_port(0, 0, 0, 3'd6, 32'd0, 0);
        wait_ack(pa, at);
        chk("abort_then_p1", 32'(pa), 32'd1);
        set_port(1, 0, 1, 3'd7, 32'h00000003, 0);
        tick(); tick();
        chk("final_hi", 32'(dev_hi), 32'd3);
        tick(); tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
